// File: rtl/mux_pkg.sv
// Shared constants and types for the 4-lane TDM mux/demux pair.
package mux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Command to the slot pointer, issued once per cycle by the framer FSM.
  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_INC   = 2'd1,
    CNT_LOAD1 = 2'd2,
    CNT_CLEAR = 2'd3
  } cnt_op_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot pointer: hold, increment with wrap at the last lane, load-to-1 on a frame start, or clear.
module tdm_slot_counter
  import mux_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  cnt_op_t op,
  output slot_t   s
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      case (op)
        CNT_INC:   s <= (s == LAST_SLOT) ? slot_t'(0) : s + slot_t'(1);
        CNT_LOAD1: s <= slot_t'(1);
        CNT_CLEAR: s <= slot_t'(0);
        default:   s <= s;
      endcase
    end
  end

endmodule

// File: rtl/demux1x4_tdm.sv
// 1:4 TDM demultiplexer: locks to a sync-marked slot 0, steers slots into lanes and publishes whole frames.
module demux1x4_tdm
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
)
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       sync,
  input  logic [WIDTH-1:0]           din,
  output logic [NUM_LANES*WIDTH-1:0] f,
  output logic [SEL_W-1:0]           s,
  output logic                       frame_valid,
  output logic                       sync_err
);

  localparam int unsigned SHADOW_LANES = NUM_LANES - 1;

  state_t  state_q;
  state_t  state_d;
  cnt_op_t cnt_op;
  logic    shadow_we;
  slot_t   shadow_sel;
  logic    frame_load;
  logic    err_c;
  slot_t   slot;

  // Lane 3 is never stored: it arrives together with the frame commit.
  logic [SHADOW_LANES-1:0][WIDTH-1:0] shadow_q;

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (cnt_op),
    .s     (slot)
  );

  assign s = slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_op     = CNT_HOLD;
    shadow_we  = 1'b0;
    shadow_sel = slot;
    frame_load = 1'b0;
    err_c      = 1'b0;

    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (sync) begin
            shadow_we  = 1'b1;
            shadow_sel = slot_t'(0);
            cnt_op     = CNT_LOAD1;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Sync restarts the frame whether on time or early; early drops the partial frame.
            err_c      = (slot != slot_t'(0));
            shadow_we  = 1'b1;
            shadow_sel = slot_t'(0);
            cnt_op     = CNT_LOAD1;
          end else if (slot == slot_t'(0)) begin
            err_c   = 1'b1;
            cnt_op  = CNT_CLEAR;
            state_d = IDLE;
          end else if (slot == LAST_SLOT) begin
            frame_load = 1'b1;
            cnt_op     = CNT_INC;
          end else begin
            shadow_we = 1'b1;
            cnt_op    = CNT_INC;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_op  = CNT_CLEAR;
        end
      endcase
    end
  end

  // Shadow lanes 0..2 collect the frame in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (shadow_we) begin
      for (int k = 0; k < int'(SHADOW_LANES); k++) begin
        if (shadow_sel == slot_t'(k)) begin
          shadow_q[k] <= din;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_load;
      sync_err    <= err_c;
      if (frame_load) begin
        f <= {din, shadow_q};
      end
    end
  end

endmodule

// File: tb/tb_demux1x4_tdm.sv
// Directed bench for demux1x4_tdm: expected frames are queued when slot 3 is driven and popped on frame_valid.
module tb_demux1x4_tdm;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       sync;
  logic [0:0] din;
  logic [3:0] f;
  logic [1:0] s;
  logic       frame_valid;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb[$];
  logic [3:0] cur_f;

  demux1x4_tdm #(.WIDTH(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .sync        (sync),
    .din         (din),
    .f           (f),
    .s           (s),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus, then check pointer, error pulse, frame pulse and frame contents.
  task automatic step(input logic v, input logic sy, input logic d,
                      input logic [1:0] exp_s, input logic exp_err, input logic push,
                      input logic [3:0] exp_f);
    @(negedge clk);
    in_valid = v;
    sync     = sy;
    din      = d;
    if (push) sb.push_back(exp_f);
    @(posedge clk);
    #1;
    chk("s", 32'(s), 32'(exp_s));
    chk("sync_err", 32'(sync_err), 32'(exp_err));
    chk("frame_valid", 32'(frame_valid), 32'(push));
    if (frame_valid) begin
      if (sb.size() == 0) begin
        chk("frame_unexpected", 32'(1), 32'(0));
      end else begin
        cur_f = sb.pop_front();
      end
    end else if (push && sb.size() != 0) begin
      void'(sb.pop_front());
    end
    chk("f", 32'(f), 32'(cur_f));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    sync     = 1'b1;
    din      = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    sb.delete();
    cur_f = 4'b0000;
    chk("rst_f", 32'(f), 32'(4'b0000));
    chk("rst_s", 32'(s), 32'(0));
    chk("rst_frame_valid", 32'(frame_valid), 32'(0));
    chk("rst_sync_err", 32'(sync_err), 32'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sync     = 1'b0;
    din      = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    din      = 1'b0;
    cur_f    = 4'b0000;

    do_reset(2);

    // Non-sync slot while hunting is silently dropped.
    step(1, 0, 1, 2'd0, 0, 0, 4'h0);

    // Clean frame 1,0,1,1 then back-to-back 0,0,1,0.
    step(1, 1, 1, 2'd1, 0, 0, 4'h0);
    step(1, 0, 0, 2'd2, 0, 0, 4'h0);
    step(1, 0, 1, 2'd3, 0, 0, 4'h0);
    step(1, 0, 1, 2'd0, 0, 1, 4'b1101);
    step(1, 1, 0, 2'd1, 0, 0, 4'h0);
    step(1, 0, 0, 2'd2, 0, 0, 4'h0);
    step(1, 0, 1, 2'd3, 0, 0, 4'h0);
    step(1, 0, 0, 2'd0, 0, 1, 4'b0100);
    step(0, 0, 1, 2'd0, 0, 0, 4'h0);

    // Gaps between slots 1 and 2; sync with in_valid low must be ignored.
    step(1, 1, 1, 2'd1, 0, 0, 4'h0);
    step(1, 0, 1, 2'd2, 0, 0, 4'h0);
    step(0, 0, 0, 2'd2, 0, 0, 4'h0);
    step(0, 1, 1, 2'd2, 0, 0, 4'h0);
    step(0, 0, 1, 2'd2, 0, 0, 4'h0);
    step(1, 0, 1, 2'd3, 0, 0, 4'h0);
    step(1, 0, 0, 2'd0, 0, 1, 4'b0111);

    // Early sync at slot 2: error, f kept, resync completes normally.
    step(1, 1, 0, 2'd1, 0, 0, 4'h0);
    step(1, 0, 1, 2'd2, 0, 0, 4'h0);
    step(1, 1, 1, 2'd1, 1, 0, 4'h0);
    step(1, 0, 0, 2'd2, 0, 0, 4'h0);
    step(1, 0, 1, 2'd3, 0, 0, 4'h0);
    step(1, 0, 1, 2'd0, 0, 1, 4'b1101);

    // Early sync at the last slot position.
    step(1, 1, 0, 2'd1, 0, 0, 4'h0);
    step(1, 0, 0, 2'd2, 0, 0, 4'h0);
    step(1, 0, 0, 2'd3, 0, 0, 4'h0);
    step(1, 1, 0, 2'd1, 1, 0, 4'h0);
    step(1, 0, 1, 2'd2, 0, 0, 4'h0);
    step(1, 0, 0, 2'd3, 0, 0, 4'h0);
    step(1, 0, 0, 2'd0, 0, 1, 4'b0010);

    // Missing sync drops to IDLE; further non-sync slots are silent.
    step(1, 0, 1, 2'd0, 1, 0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1'(i), 2'd0, 0, 0, 4'h0);
    end
    step(1, 1, 0, 2'd1, 0, 0, 4'h0);
    step(1, 0, 1, 2'd2, 0, 0, 4'h0);
    step(1, 0, 1, 2'd3, 0, 0, 4'h0);
    step(1, 0, 0, 2'd0, 0, 1, 4'b0110);

    // Reset after slot 2 of a frame, then a clean frame.
    step(1, 1, 1, 2'd1, 0, 0, 4'h0);
    step(1, 0, 1, 2'd2, 0, 0, 4'h0);
    do_reset(1);
    step(1, 0, 1, 2'd0, 0, 0, 4'h0);
    step(1, 1, 1, 2'd1, 0, 0, 4'h0);
    step(1, 0, 0, 2'd2, 0, 0, 4'h0);
    step(1, 0, 0, 2'd3, 0, 0, 4'h0);
    step(1, 0, 1, 2'd0, 0, 1, 4'b1001);
    step(0, 0, 0, 2'd0, 0, 0, 4'h0);

    chk("scoreboard_empty", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
